// File: rtl/fib_bcd_conv_if.sv
// Sample-in / BCD-out stream bundle between the Fibonacci generator, the
// BCD converter and the display readout.
interface fib_bcd_conv_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
);
  logic                  in_valid;
  logic [WIDTH-1:0]      in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bcd
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bcd
  );
endinterface

// File: rtl/fib_bcd_conv.sv
// Binary-to-packed-BCD converter (double-dabble, one bit per cycle) behind a
// one-entry holding register that absorbs the non-stallable generator stream.
module fib_bcd_conv #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic          clock,
  input  logic          reset,
  fib_bcd_conv_if.slave bus,
  output logic          busy,
  output logic          drop_flag
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned BW = 4 * DIGITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    out_bcd_q, out_bcd_d;
  logic             drop_q, drop_d;

  logic             load;
  logic             accept;
  logic [BW-1:0]    bcd_adj;
  logic [BW+WIDTH-1:0] cat_sh;

  // Per-digit +3 correction; digits never carry into each other.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    cat_sh = {bcd_adj, bin_q} << 1;
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    out_bcd_d = out_bcd_q;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          bin_d   = hold_data_q;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {bcd_d, bin_d} = cat_sh;
        cnt_d          = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          out_bcd_d = cat_sh[BW+WIDTH-1 -: BW];
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The load edge frees the holding slot, so a sample arriving on that same
  // edge is taken even though in_ready still reads 0.
  always_comb begin
    accept      = bus.in_valid & (~hold_full_q | load);
    hold_full_d = accept | (hold_full_q & ~load);
    hold_data_d = accept ? bus.in_data : hold_data_q;
    drop_d      = drop_q | (bus.in_valid & hold_full_q & ~load);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      out_bcd_q   <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      out_bcd_q   <= out_bcd_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.in_ready  = ~hold_full_q;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_bcd   = out_bcd_q;
  assign busy          = (state_q != S_IDLE);
  assign drop_flag     = drop_q;

endmodule

// File: tb/tb_fib_bcd_conv.sv
// Bench for fib_bcd_conv: directed vector table and corner sequences, plus
// randomized traffic checked every cycle against an arithmetic reference.
module tb_fib_bcd_conv;
  localparam int unsigned W = 16;
  localparam int unsigned D = 5;

  typedef struct {
    int unsigned    din;
    logic [4*D-1:0] exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  logic busy;
  logic drop_flag;

  fib_bcd_conv_if #(.WIDTH(W), .DIGITS(D)) bus ();

  fib_bcd_conv #(.WIDTH(W), .DIGITS(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .drop_flag (drop_flag)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*D-1:0] to_bcd(input int unsigned v);
    logic [4*D-1:0] r;
    int unsigned    x;
    r = '0;
    x = v;
    for (int unsigned i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference: occupancy of the holding slot plus a converter that is idle,
  // counting down WIDTH shift cycles, or presenting a finished result.
  bit             m_full;
  int unsigned    m_data, m_val, m_left;
  int             m_st;
  logic [4*D-1:0] m_out;
  bit             m_drop;

  task automatic model_step();
    bit ld, acc;
    if (reset) begin
      m_full = 0; m_data = 0; m_val = 0; m_left = 0; m_st = 0; m_out = '0; m_drop = 0;
    end else begin
      ld  = (m_st == 0) && m_full;
      acc = bus.in_valid && (!m_full || ld);
      if (bus.in_valid && m_full && !ld) m_drop = 1;
      if (ld) begin
        m_val = m_data; m_left = W; m_st = 1;
      end else if (m_st == 1) begin
        m_left--;
        if (m_left == 0) begin
          m_st = 2; m_out = to_bcd(m_val);
        end
      end else if (m_st == 2 && bus.out_ready) begin
        m_st = 0;
      end
      if (acc) begin
        m_full = 1; m_data = int'(bus.in_data);
      end else if (ld) begin
        m_full = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clock or posedge reset);
    model_step();
  end

  bit chk_en = 0;
  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      check("in_ready",  32'(bus.in_ready),  32'(!m_full));
      check("out_valid", 32'(bus.out_valid), 32'(m_st == 2));
      check("out_bcd",   32'(bus.out_bcd),   32'(m_out));
      check("busy",      32'(busy),          32'(m_st != 0));
      check("drop_flag", 32'(drop_flag),     32'(m_drop));
    end
  end

  logic [4*D-1:0] res_q[$];
  bit prev_ov = 0;
  initial forever begin
    @(negedge clock);
    if (bus.out_valid && !prev_ov) res_q.push_back(bus.out_bcd);
    prev_ov = bus.out_valid;
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    res_q.delete();
  endtask

  task automatic pulse(input int unsigned v);
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'(v);
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || !bus.in_ready) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      n_vec++; n_err++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clock);
      lat++;
    end
  endtask

  vec_t tbl[7];
  int   lat;
  int unsigned fa, fb, ft;
  int unsigned sent[$];
  bit found;

  initial begin
    tbl[0] = '{46368, 20'h46368};
    tbl[1] = '{0,     20'h00000};
    tbl[2] = '{1,     20'h00001};
    tbl[3] = '{9,     20'h00009};
    tbl[4] = '{10,    20'h00010};
    tbl[5] = '{65535, 20'h65535};
    tbl[6] = '{1597,  20'h01597};

    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    chk_en = 1;
    repeat (2) @(negedge clock);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_bcd",   32'(bus.out_bcd),   32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_drop",      32'(drop_flag),     32'd0);
    reset = 1'b0;

    // Directed table: latency and exact BCD for boundary values.
    for (int i = 0; i < 7; i++) begin
      wait_idle();
      pulse(tbl[i].din);
      wait_valid(lat);
      check("latency", 32'(lat), 32'd17);
      check("tbl_bcd", 32'(bus.out_bcd), 32'(tbl[i].exp));
    end
    check("tbl_drop", 32'(drop_flag), 32'd0);

    // Backpressure: result held while a second sample waits in the slot.
    wait_idle();
    bus.out_ready = 1'b0;
    pulse(233);
    wait_valid(lat);
    pulse(377);
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      check("bp_valid",    32'(bus.out_valid), 32'd1);
      check("bp_bcd",      32'(bus.out_bcd),   32'h00233);
      check("bp_in_ready", 32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    wait_valid(lat);
    check("bp_next_bcd", 32'(bus.out_bcd), 32'h00377);
    check("bp_drop", 32'(drop_flag), 32'd0);

    // Sample B arrives on the very edge the converter loads held sample A.
    wait_idle();
    do_reset();
    pulse(100);
    pulse(4181);
    lat = 0;
    while (!(!busy && !bus.in_ready) && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    check("sim_reach_load", 32'(lat < 100), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'(6765);
    @(negedge clock);
    bus.in_valid = 1'b0;
    wait_idle();
    check("sim_count", 32'(res_q.size()), 32'd3);
    if (res_q.size() == 3) begin
      check("sim_x", 32'(res_q[0]), 32'h00100);
      check("sim_a", 32'(res_q[1]), 32'h04181);
      check("sim_b", 32'(res_q[2]), 32'h06765);
    end
    check("sim_drop", 32'(drop_flag), 32'd0);

    // Overrun: generator streams every cycle, ignoring in_ready.
    do_reset();
    sent.delete();
    fa = 0; fb = 1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clock);
      if (k == 2) check("ovr_drop_early", 32'(drop_flag), 32'd0);
      if (k == 3) check("ovr_drop_set",   32'(drop_flag), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(fa);
      sent.push_back(fa % 65536);
      ft = fb; fb = (fa + fb) % 65536; fa = ft;
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
    wait_idle();
    check("ovr_results", 32'(res_q.size() >= 3), 32'd1);
    foreach (res_q[j]) begin
      found = 0;
      foreach (sent[s]) if (to_bcd(sent[s]) == res_q[j]) found = 1;
      check("ovr_result_valid", 32'(found), 32'd1);
    end

    // Random traffic against the reference.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      bus.in_valid  = ($urandom_range(0, 3) == 0);
      bus.in_data   = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 1) == 1);
    end
    @(negedge clock);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();

    // Asynchronous reset in the middle of a conversion with the slot full.
    do_reset();
    pulse(1000);
    pulse(2000);
    repeat (6) @(negedge clock);
    check("mid_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_in_ready",  32'(bus.in_ready),  32'd1);
    check("async_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_out_bcd",   32'(bus.out_bcd),   32'd0);
    check("async_busy",      32'(busy),          32'd0);
    check("async_drop",      32'(drop_flag),     32'd0);
    @(negedge clock);
    reset = 1'b0;
    wait_idle();
    pulse(1597);
    wait_valid(lat);
    check("post_rst_latency", 32'(lat), 32'd17);
    check("post_rst_bcd", 32'(bus.out_bcd), 32'h01597);
    wait_idle();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
